// File: rtl/id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : MIPS decode stage - register file, control decode, branch/jump
//            resolution, load-use stall and the ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
module id_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr_id,
    input  logic [31:0]           pc_id,
    input  logic                  wb_en,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  stall,
    output logic                  branch,
    output logic                  jump,
    output logic [31:0]           branch_target,
    output logic [31:0]           jump_target,
    output logic [DATA_WIDTH-1:0] ex_rs_data,
    output logic [DATA_WIDTH-1:0] ex_rt_data,
    output logic [31:0]           ex_imm,
    output logic [4:0]            ex_dest,
    output logic [2:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_illegal
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_SLT = 3'd4;

    logic [DATA_WIDTH-1:0] rf_q [32];

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_ext;

    assign w_opcode  = instr_id[31:26];
    assign w_funct   = instr_id[5:0];
    assign w_rs      = instr_id[25:21];
    assign w_rt      = instr_id[20:16];
    assign w_rd      = instr_id[15:11];
    assign w_imm_ext = {{16{instr_id[15]}}, instr_id[15:0]};

    // Register file: reset wins over a coincident writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
            rf_q[29] <= SP_INIT;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    logic [DATA_WIDTH-1:0] w_rs_val;
    logic [DATA_WIDTH-1:0] w_rt_val;

    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_rs != 5'd0) begin
            w_rs_val = (wb_en && (wb_addr == w_rs)) ? wb_data : rf_q[w_rs];
        end
        if (w_rt != 5'd0) begin
            w_rt_val = (wb_en && (wb_addr == w_rt)) ? wb_data : rf_q[w_rt];
        end
    end

    logic       w_valid;
    logic       w_illegal;
    logic       w_use_rs;
    logic       w_use_rt;
    logic       w_is_beq;
    logic       w_is_bne;
    logic       w_is_j;
    logic [2:0] w_alu_op;
    logic       w_alu_src;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic [4:0] w_dest;

    always_comb begin
        w_valid      = 1'b0;
        w_illegal    = 1'b0;
        w_use_rs     = 1'b0;
        w_use_rt     = 1'b0;
        w_is_beq     = 1'b0;
        w_is_bne     = 1'b0;
        w_is_j       = 1'b0;
        w_alu_op     = c_ALU_ADD;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_dest       = 5'd0;
        if (instr_id != 32'd0) begin
            w_use_rs = 1'b1;
            case (w_opcode)
                c_OP_RTYPE: begin
                    w_use_rt    = 1'b1;
                    w_valid     = 1'b1;
                    w_reg_write = 1'b1;
                    w_dest      = w_rd;
                    case (w_funct)
                        6'h20:   w_alu_op = c_ALU_ADD;
                        6'h22:   w_alu_op = c_ALU_SUB;
                        6'h24:   w_alu_op = c_ALU_AND;
                        6'h25:   w_alu_op = c_ALU_OR;
                        6'h2A:   w_alu_op = c_ALU_SLT;
                        default: begin
                            w_valid     = 1'b0;
                            w_illegal   = 1'b1;
                            w_reg_write = 1'b0;
                            w_dest      = 5'd0;
                        end
                    endcase
                end
                c_OP_ADDI: begin
                    w_valid     = 1'b1;
                    w_alu_src   = 1'b1;
                    w_reg_write = 1'b1;
                    w_dest      = w_rt;
                end
                c_OP_LW: begin
                    w_valid      = 1'b1;
                    w_alu_src    = 1'b1;
                    w_mem_read   = 1'b1;
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_dest       = w_rt;
                end
                c_OP_SW: begin
                    w_valid     = 1'b1;
                    w_use_rt    = 1'b1;
                    w_alu_src   = 1'b1;
                    w_mem_write = 1'b1;
                end
                c_OP_BEQ: begin
                    w_valid  = 1'b1;
                    w_use_rt = 1'b1;
                    w_is_beq = 1'b1;
                end
                c_OP_BNE: begin
                    w_valid  = 1'b1;
                    w_use_rt = 1'b1;
                    w_is_bne = 1'b1;
                end
                c_OP_J: begin
                    w_valid  = 1'b1;
                    w_use_rs = 1'b0;
                    w_is_j   = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_WIDTH-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [31:0]           ex_imm_q, ex_imm_d;
    logic [4:0]            ex_dest_q, ex_dest_d;
    logic [2:0]            ex_alu_op_q, ex_alu_op_d;
    logic                  ex_alu_src_q, ex_alu_src_d;
    logic                  ex_mem_read_q, ex_mem_read_d;
    logic                  ex_mem_write_q, ex_mem_write_d;
    logic                  ex_reg_write_q, ex_reg_write_d;
    logic                  ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic                  ex_illegal_q, ex_illegal_d;

    // Load-use: the load in EX has not produced its data yet.
    assign stall = ex_mem_read_q && (ex_dest_q != 5'd0) &&
                   ((w_use_rs && (w_rs == ex_dest_q)) ||
                    (w_use_rt && (w_rt == ex_dest_q)));

    assign branch = !stall && ((w_is_beq && (w_rs_val == w_rt_val)) ||
                               (w_is_bne && (w_rs_val != w_rt_val)));
    assign jump   = !stall && w_is_j;

    assign branch_target = pc_id + 32'd4 + {w_imm_ext[29:0], 2'b00};
    assign jump_target   = {pc_id[31:28], instr_id[25:0], 2'b00};

    always_comb begin
        ex_rs_data_d    = '0;
        ex_rt_data_d    = '0;
        ex_imm_d        = '0;
        ex_dest_d       = 5'd0;
        ex_alu_op_d     = c_ALU_ADD;
        ex_alu_src_d    = 1'b0;
        ex_mem_read_d   = 1'b0;
        ex_mem_write_d  = 1'b0;
        ex_reg_write_d  = 1'b0;
        ex_mem_to_reg_d = 1'b0;
        ex_illegal_d    = w_illegal && !stall;
        if (w_valid && !stall) begin
            ex_rs_data_d    = w_rs_val;
            ex_rt_data_d    = w_rt_val;
            ex_imm_d        = w_imm_ext;
            ex_dest_d       = w_dest;
            ex_alu_op_d     = w_alu_op;
            ex_alu_src_d    = w_alu_src;
            ex_mem_read_d   = w_mem_read;
            ex_mem_write_d  = w_mem_write;
            ex_reg_write_d  = w_reg_write;
            ex_mem_to_reg_d = w_mem_to_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs_data_q    <= '0;
            ex_rt_data_q    <= '0;
            ex_imm_q        <= '0;
            ex_dest_q       <= 5'd0;
            ex_alu_op_q     <= 3'd0;
            ex_alu_src_q    <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_illegal_q    <= 1'b0;
        end else begin
            ex_rs_data_q    <= ex_rs_data_d;
            ex_rt_data_q    <= ex_rt_data_d;
            ex_imm_q        <= ex_imm_d;
            ex_dest_q       <= ex_dest_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            ex_illegal_q    <= ex_illegal_d;
        end
    end

    assign ex_rs_data    = ex_rs_data_q;
    assign ex_rt_data    = ex_rt_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_dest       = ex_dest_q;
    assign ex_alu_op     = ex_alu_op_q;
    assign ex_alu_src    = ex_alu_src_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_to_reg = ex_mem_to_reg_q;
    assign ex_illegal    = ex_illegal_q;

endmodule
`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; consumes the instruction word latched by the fetch stage.
- Holds the 32x32 register file and decodes control signals.
- Resolves beq/bne/j in ID and returns branch/jump redirect signals to fetch.
- Detects load-use hazards and registers all decoded operands and controls into the ID/EX pipeline register.

Parameters:
- DATA_WIDTH, 32, width of register-file entries and operand buses.
- SP_INIT, 32'd0, reset value of register 29 ($sp); all other registers reset to 0.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- instr_id  in  32  instruction in ID (0 = nop).
- pc_id  in  32  address of the instruction in ID.
- wb_en  in  1  writeback enable from WB stage.
- wb_addr  in  5  writeback register index.
- wb_data  in  DATA_WIDTH  writeback value.
- stall  out  1  combinational; fetch holds PC and instr_id when 1.
- branch  out  1  combinational; taken beq/bne in ID.
- jump  out  1  combinational; j in ID.
- branch_target  out  32  pc_id+4+(sign_ext(imm)<<2).
- jump_target  out  32  {pc_id[31:28], instr_id[25:0], 2'b00}.
- ex_rs_data, ex_rt_data  out  DATA_WIDTH  registered operands.
- ex_imm  out  32  registered sign-extended immediate.
- ex_dest  out  5  registered destination (rd for R-type, rt for addi/lw).
- ex_alu_op  out  3  registered: 0 add, 1 sub, 2 and, 3 or, 4 slt.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered controls.
- ex_illegal  out  1  registered; unsupported opcode/funct.

Behaviour:
- Reset (sync, high): all ex_* outputs 0; registers 0 except $29 = SP_INIT. stall/branch/jump follow combinational decode of current inputs.
- Decode set:
  - R-type op 0: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Opcodes 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j.
  - instr_id==0 is a nop: all controls 0, ex_illegal 0.
  - Anything else: bubble with ex_illegal=1 for one cycle.
- Register file:
  - Write at posedge when wb_en && wb_addr!=0. $0 always reads 0.
  - Read is combinational, with bypass: wb_en && wb_addr==src && src!=0 returns wb_data in the same cycle.
- Branch:
  - Compare bypassed rs/rt values.
  - branch=1 for beq when equal, bne when unequal.
  - Immediate is sign-extended; 0xFFFC gives target pc_id+4-16.
- Jump: jump=1 whenever opcode 0x02 and not stalled.
- Load-use hazard:
  - stall=1 when ex_mem_read && ex_dest!=0 && ex_dest matches a source register of instr_id.
  - rs is used by all except j/nop. rt is used by R-type, beq, bne, sw.
  - While stalled: branch=jump=0 and the ID/EX register loads a bubble (all controls 0).
  - Next cycle ex_mem_read=0, so stall self-clears after exactly 1 cycle.
- ID/EX register latency: 1 cycle. ex_* reflect instr_id from the previous posedge.
- Branches and jumps: write no register; ex_reg_write=0.
- Simultaneous writeback and read of the same register: bypass value wins. Writeback during stall still commits.
- Reset mid-stream: ID/EX cleared on the next posedge and register contents lost. Reset overrides any pending writeback in the same cycle.
- Arithmetic: branch_target wraps modulo 2^32.

Test Plan:
- Reset: assert reset 1 cycle with wb_en=1 -> all ex_*=0, $29=SP_INIT, $5 reads 0 afterwards.
- addi: write $16=100 via WB, then instr_id=0x22090190 (addi $9,$16,400) -> next cycle ex_rs_data=100, ex_imm=400, ex_dest=9, ex_alu_src=1, ex_reg_write=1, ex_alu_op=0.
- Bypass and $0: same-cycle wb_en=1, wb_addr=9, wb_data=7 with add $17,$9,$0 in ID -> ex_rs_data=7, ex_rt_data=0. A write to $0 leaves $0 reading 0.
- Branch taken/not taken:
  - pc_id=44, bne $9,$16,-4 with $9=396, $16=0 -> branch=1, branch_target=32.
  - With $9=$16 -> branch=0.
- Load-use: lw $17,0($9) then add $18,$18,$17 -> stall=1 for exactly one cycle, bubble in ID/EX, then add decoded with ex_rt_data from the bypassed WB value.
- Jump/illegal:
  - instr 0x08000004 at pc_id=8 -> jump=1, jump_target=16.
  - Opcode 0x3F -> ex_illegal=1 for one cycle with all controls 0.
